multiplexer_2_1_ternary: RTL and testbench
==========================================

# multiplexer_2_1_ternary

Two-input, one-output selector with a combinational path and a registered copy of the selected value. Each data leg is WIDTH bits; `s` picks leg 1 when high and leg 0 when low. It is a leaf datapath primitive used wherever a single-level choice between two sources is needed. The registered output and the select-change counter support pipelined consumers and debug.

## Interface
- WIDTH, 1, bit width of each data leg (≥1)
- CNT_W, 8, width of the select-change counter (≥1)

- clk  input  1  single clock; all registers update on its rising edge
- rst  input  1  reset, asynchronous and active-high
- i  input  2*WIDTH  packed data legs: leg 0 = i[WIDTH-1:0], leg 1 = i[2*WIDTH-1:WIDTH]
- s  input  1  select: 0 → leg 0, 1 → leg 1
- f  output  WIDTH  combinational selected data
- f_q  output  WIDTH  registered selected data
- s_q  output  1  registered select
- sel_changes  output  CNT_W  saturating count of clocked edges where s differs from s_q

## Operation
- f = s ? leg 1 : leg 0, purely combinational, with no dependence on clk or rst.
- With WIDTH=1: f = s ? i[1] : i[0].
- X/Z on `s` must not be masked. f is X when s is X and the legs differ. When both legs are equal, f equals that value regardless of s (ternary semantics).
- On each rising clk with rst low:
  - f_q ← f
  - s_q ← s
  - if s ≠ s_q and sel_changes < 2^CNT_W−1, then sel_changes ← sel_changes+1
- sel_changes saturates at all-ones and holds there until reset. It never wraps.
- No enable, handshake or back-pressure. Every cycle is accepted.

## Timing
- f: zero-cycle latency, combinational from i and s.
- f_q, s_q: exactly one-cycle latency from i and s sampled at the rising edge.
- Reset is asserted asynchronously and takes effect immediately. While rst is high:
  - f_q = 0
  - s_q = 0
  - sel_changes = 0
- f remains live during reset.
- Reset release: the first update occurs on the first rising clk after rst deasserts.
- Reset mid-operation clears all registers at once. The select-change comparison then restarts against s_q = 0, so a high s on the first post-reset edge counts as one change.
- Simultaneous change of i and s in the same cycle: f_q captures the leg chosen by the new s.

## Test plan
- Combinational truth, WIDTH=1, 5 time units apart, no clock required. Each step requires:
  - i=00, s=0 → f=0
  - i=01, s=1 → f=0
  - i=10, s=0 → f=0
  - i=11, s=1 → f=1
- Leg isolation, WIDTH=1:
  - i=01, s=0 → f=1
  - i=10, s=1 → f=1
- Registered path, WIDTH=4, i=0xA5:
  - s=0 → f=5 immediately; f_q=5 after one rising edge
  - then s=1 → f=A immediately; f_q=A one edge later
- Async reset: with f_q=A, sel_changes=3, assert rst between clock edges:
  - f_q=0, s_q=0, sel_changes=0 immediately, with no clock edge
  - f still tracks i and s during reset
- Counter saturation, CNT_W=2:
  - toggle s every cycle for 6 cycles → sel_changes counts 1, 2, 3, then holds at 3
  - holding s constant adds no further counts
- First edge after reset with s=1 → s_q=1 and sel_changes=1.

Source files
------------

// File: rtl/multiplexer_2_1_ternary_if.sv
// Bundle of data, select and observation signals for the 2:1 selector.
// The master drives legs and select; the slave returns the selected and registered values.
interface multiplexer_2_1_ternary_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [2*WIDTH-1:0] i;
  logic               s;
  logic [WIDTH-1:0]   f;
  logic [WIDTH-1:0]   f_q;
  logic               s_q;
  logic [CNT_W-1:0]   sel_changes;

  modport master (
    output i,
    output s,
    input  f,
    input  f_q,
    input  s_q,
    input  sel_changes
  );

  modport slave (
    input  i,
    input  s,
    output f,
    output f_q,
    output s_q,
    output sel_changes
  );
endinterface

// File: rtl/multiplexer_2_1_ternary.sv
// 2:1 selector with a live combinational output, a registered copy of it,
// and a saturating counter of clocked select changes for debug.
module multiplexer_2_1_ternary #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  multiplexer_2_1_ternary_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] leg0;
  logic [WIDTH-1:0] leg1;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] f_q;
  logic             s_d;
  logic             s_q;
  logic [CNT_W-1:0] sel_changes_d;
  logic [CNT_W-1:0] sel_changes_q;

  assign leg0 = bus.i[WIDTH-1:0];
  assign leg1 = bus.i[2*WIDTH-1:WIDTH];

  // The ternary keeps X on s visible where the legs differ and resolves it where they agree.
  always_comb begin
    f_d           = bus.s ? leg1 : leg0;
    s_d           = bus.s;
    sel_changes_d = sel_changes_q;
    if ((bus.s != s_q) && (sel_changes_q != CNT_MAX)) begin
      sel_changes_d = sel_changes_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q           <= '0;
      s_q           <= 1'b0;
      sel_changes_q <= '0;
    end else begin
      f_q           <= f_d;
      s_q           <= s_d;
      sel_changes_q <= sel_changes_d;
    end
  end

  assign bus.f           = f_d;
  assign bus.f_q         = f_q;
  assign bus.s_q         = s_q;
  assign bus.sel_changes = sel_changes_q;

endmodule

// File: tb/tb_multiplexer_2_1_ternary.sv
// Bench for the 2:1 selector: directed combinational checks plus a scoreboard
// comparing registered outputs against a select/leg reference model.
module tb_multiplexer_2_1_ternary;

  logic clk;
  logic rst;

  multiplexer_2_1_ternary_if #(.WIDTH(1), .CNT_W(8)) bus_a ();
  multiplexer_2_1_ternary_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  multiplexer_2_1_ternary #(.WIDTH(1), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  multiplexer_2_1_ternary #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic [3:0] f_q;
    logic       s_q;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_s_q  = 0;
  int   m_cnt  = 0;
  int   cnt_max_b = 3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Selected leg computed arithmetically: shift by s legs, keep w bits.
  function automatic int legOf(int packed_i, int sel, int w);
    return (packed_i >> (sel * w)) % (1 << w);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives both DUTs, checks f immediately and queues the expected registered state.
  task automatic applyStimulus(logic [7:0] ib, logic sb, logic [1:0] ia, logic sa);
    int exp_f;
    exp_t e;
    bus_b.i = ib;
    bus_b.s = sb;
    bus_a.i = ia;
    bus_a.s = sa;
    #1;
    exp_f = legOf(int'(ib), int'(sb), 4);
    checkOutput("f_b", 32'(bus_b.f), 32'(exp_f));
    checkOutput("f_a", 32'(bus_a.f), 32'(legOf(int'(ia), int'(sa), 1)));
    if (int'(sb) != m_s_q && m_cnt < cnt_max_b) m_cnt++;
    m_s_q = int'(sb);
    e.f_q = 4'(exp_f);
    e.s_q = sb;
    e.cnt = 2'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic combStep(string name, logic [1:0] ia, logic sa, logic ef);
    bus_a.i = ia;
    bus_a.s = sa;
    #1;
    checkOutput(name, 32'(bus_a.f), 32'(ef));
    #4;
  endtask

  // Asserts reset between edges, checks the immediate clear and live f, then releases on a negedge.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_f_q", 32'(bus_b.f_q), 32'd0);
    checkOutput("rst_s_q", 32'(bus_b.s_q), 32'd0);
    checkOutput("rst_cnt", 32'(bus_b.sel_changes), 32'd0);
    bus_b.i = 8'hA5;
    bus_b.s = 1'b0;
    #1;
    checkOutput("rst_f_leg0", 32'(bus_b.f), 32'h5);
    bus_b.s = 1'b1;
    #1;
    checkOutput("rst_f_leg1", 32'(bus_b.f), 32'hA);
    sb_q.delete();
    m_s_q = 0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every registered update is compared with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("f_q", 32'(bus_b.f_q), 32'(e.f_q));
        checkOutput("s_q", 32'(bus_b.s_q), 32'(e.s_q));
        checkOutput("sel_changes", 32'(bus_b.sel_changes), 32'(e.cnt));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    bus_a.i = '0;
    bus_a.s = 1'b0;
    bus_b.i = '0;
    bus_b.s = 1'b0;
    #1;
    checkOutput("init_f_q", 32'(bus_b.f_q), 32'd0);
    checkOutput("init_s_q", 32'(bus_b.s_q), 32'd0);
    checkOutput("init_cnt", 32'(bus_b.sel_changes), 32'd0);

    combStep("truth_00_s0", 2'b00, 1'b0, 1'b0);
    combStep("truth_01_s1", 2'b01, 1'b1, 1'b0);
    combStep("truth_10_s0", 2'b10, 1'b0, 1'b0);
    combStep("truth_11_s1", 2'b11, 1'b1, 1'b1);
    combStep("iso_01_s0",   2'b01, 1'b0, 1'b1);
    combStep("iso_10_s1",   2'b10, 1'b1, 1'b1);

    // Registered path and counter build-up to 3 with f_q ending at A.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hA5, 1'b0, 2'b01, 1'b0);
    @(negedge clk); applyStimulus(8'hA5, 1'b1, 2'b10, 1'b1);
    @(negedge clk); applyStimulus(8'hA5, 1'b0, 2'b10, 1'b0);
    @(negedge clk); applyStimulus(8'hA5, 1'b1, 2'b01, 1'b1);

    // Mid-operation reset; first post-reset edge with s=1 counts once.
    doReset();
    applyStimulus(8'hA5, 1'b1, 2'b11, 1'b0);
    @(negedge clk); applyStimulus(8'h3C, 1'b1, 2'b00, 1'b1);

    // Saturation: six toggles, then a constant select.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'((k + 1) % 2), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    // Randomized traffic from a fresh reset.
    doReset();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (k != 39) @(negedge clk);
    end

    @(posedge clk);
    #2;
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
